cory_unpack_ser: RTL and testbench
==================================

CORY_UNPACK_SER -- requirements
Module: cory_unpack_ser

Interface
REQ-001 Parameter N, default 8: beat width in bits on the output side.
REQ-002 Parameter M, default 4: beats per input word, legal values 1 to 256.
REQ-003 Derived parameter A = N*M is the input word width; derived parameter C = max(1, clog2(M)) is the beat-counter width.
REQ-004 Port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 Port reset_n  input  1: asynchronous active-low reset.
REQ-006 Port i_a_v  input  1: input word valid.
REQ-007 Port i_a_d  input  A: input word; beat k is bits [k*N +: N].
REQ-008 Port o_a_r  output  1: input ready.
REQ-009 Port o_z_v  output  1: output beat valid.
REQ-010 Port o_z_d  output  N: output beat data.
REQ-011 Port o_z_last  output  1: marks the final beat of the current word.
REQ-012 Port i_z_r  input  1: output ready.

Function
REQ-013 The block is a width down-converter: each accepted A-bit word is emitted as M N-bit beats, least-significant beat first.
REQ-014 Handshakes: a word transfers when i_a_v && o_a_r; a beat transfers when o_z_v && i_z_r.
REQ-015 State: holding register buf[A], beat counter cnt[C], occupancy flag full.
REQ-016 o_z_v = full; o_z_d = buf[cnt*N +: N]; o_z_last = full && (cnt == last index).
REQ-017 o_a_r = !full || (i_z_r && o_z_last); the combinational path from i_z_r to o_a_r is intended and allows back-to-back words.
REQ-018 On an input transfer: buf <= i_a_d, cnt <= 0, full <= 1; the first beat is valid on the next cycle (latency 1).
REQ-019 On an output transfer that is not the last beat: cnt <= cnt+1; buf is unchanged.
REQ-020 On an output transfer of the last beat with no simultaneous input transfer: full <= 0, cnt <= 0.
REQ-021 When the last-beat output transfer and an input transfer occur in the same cycle, the input transfer wins: the new word loads with cnt=0 and full stays 1, with no bubble.
REQ-022 While o_z_v && !i_z_r, o_z_d and o_z_last are held stable.
REQ-023 Sustained throughput is one word per M cycles with i_z_r held at 1.
REQ-024 With M=1, each word produces one beat with o_z_last=1, and the block sustains one word per cycle.
REQ-025 i_a_d is ignored when no input transfer occurs.
REQ-026 Behaviour for i_a_v and i_a_d changing while o_a_r=0 is undefined for this block; upstream holds them per the handshake protocol.

Reset
REQ-027 While reset_n=0, immediately and independent of clk: full=0, cnt=0, buf=0, so o_z_v=0, o_z_last=0, o_z_d=0, and o_a_r=1.
REQ-028 Reset asserted mid-word discards the remaining beats; after release, the next accepted word starts at beat 0.

Configuration
REQ-029 Macro CORY_UNPACK_SER_LEN_EN compiles in the short-word feature.
REQ-030 With CORY_UNPACK_SER_LEN_EN defined:
- adds port i_a_len  input  C: number of beats minus 1.
- i_a_len is latched with the word into register len.
- the last index is len; values of len >= M are treated as M-1.
REQ-031 Without CORY_UNPACK_SER_LEN_EN: no i_a_len port, no len register, and the last index is the constant M-1.

Verification (N=8, M=4)
REQ-032 Word 0x44332211, i_z_r=1 -> o_z_d 0x11,0x22,0x33,0x44 on cycles 1-4 after acceptance; o_z_last only with 0x44.
REQ-033 Words 0x44332211 then 0x88776655 presented back-to-back, i_z_r=1 -> 8 consecutive valid beats; o_a_r=1 on the 0x44 cycle; no gap.
REQ-034 i_z_r=0 for 3 cycles during beat 0x22 -> 0x22 held with o_z_v=1 for those cycles; o_a_r=0 throughout; sequence then resumes 0x33,0x44.
REQ-035 reset_n pulsed low after beat 0x22 -> o_z_v=0 asynchronously; the next word 0xDDCCBBAA yields 0xAA first.
REQ-036 M=1, continuous words 0x5A,0xA5 -> one beat per cycle, o_z_last=1 on each beat, o_a_r constant 1.
REQ-037 With CORY_UNPACK_SER_LEN_EN, word 0x44332211 with i_a_len=1 -> beats 0x11,0x22; o_z_last on 0x22; o_a_r=1 in that cycle.

Source files
------------

// File: rtl/cory_unpack_ser.sv
// Width down-converter: each accepted N*M-bit word leaves as M N-bit beats, LS beat first.
// Optional short-word support (per-word beat count) is compiled in by CORY_UNPACK_SER_LEN_EN.
module cory_unpack_ser #(
  parameter int N = 8,
  parameter int M = 4,
  localparam int A = N * M,
  localparam int C = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_a_v,
  input  logic [A-1:0] i_a_d,
`ifdef CORY_UNPACK_SER_LEN_EN
  input  logic [C-1:0] i_a_len,
`endif
  output logic         o_a_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic         o_z_last,
  input  logic         i_z_r
);

  localparam logic [C-1:0] LAST_MAX = C'(M - 1);

  logic [A-1:0]        buf_q, buf_d;
  logic [C-1:0]        cnt_q, cnt_d;
  logic                full_q, full_d;
  logic [C-1:0]        last_idx;
  logic [M-1:0][N-1:0] beats;
  logic                a_fire;
  logic                z_fire;

`ifdef CORY_UNPACK_SER_LEN_EN
  localparam logic [C:0] M_EXT = (C + 1)'(M);
  logic [C-1:0] len_q, len_d;

  // Out-of-range lengths are clamped once at load so the counter never runs past the word.
  always_comb begin
    len_d = len_q;
    if (a_fire) begin
      len_d = ({1'b0, i_a_len} >= M_EXT) ? LAST_MAX : i_a_len;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q <= '0;
    end else begin
      len_q <= len_d;
    end
  end

  assign last_idx = len_q;
`else
  assign last_idx = LAST_MAX;
`endif

  assign beats = buf_q;

  always_comb begin
    o_z_v    = full_q;
    o_z_d    = beats[cnt_q];
    o_z_last = full_q && (cnt_q == last_idx);
    // Ready may follow i_z_r combinationally so a new word can load as the last beat leaves.
    o_a_r    = !full_q || (i_z_r && o_z_last);
    a_fire   = i_a_v && o_a_r;
    z_fire   = o_z_v && i_z_r;
  end

  always_comb begin
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    full_d = full_q;
    if (a_fire) begin
      buf_d  = i_a_d;
      cnt_d  = '0;
      full_d = 1'b1;
    end else if (z_fire) begin
      if (o_z_last) begin
        cnt_d  = '0;
        full_d = 1'b0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      buf_q  <= buf_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

endmodule

// File: tb/tb_cory_unpack_ser.sv
// Self-checking bench for cory_unpack_ser: directed scenarios plus a randomized run
// checked against a queue-of-beats reference model. Covers CORY_UNPACK_SER_LEN_EN when defined.
module tb_cory_unpack_ser;

  logic        clk;
  logic        reset_n;
  logic        i_a_v;
  logic [31:0] i_a_d;
  logic        o_a_r;
  logic        o_z_v;
  logic [7:0]  o_z_d;
  logic        o_z_last;
  logic        i_z_r;

  logic        m1_a_v;
  logic [7:0]  m1_a_d;
  logic        m1_a_r;
  logic        m1_z_v;
  logic [7:0]  m1_z_d;
  logic        m1_z_last;
  logic        m1_z_r;

`ifdef CORY_UNPACK_SER_LEN_EN
  logic [1:0]  i_a_len;
  logic [0:0]  m1_a_len;
`endif

  int tests_run;
  int tests_failed;

  cory_unpack_ser #(.N(8), .M(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_a_v    (i_a_v),
    .i_a_d    (i_a_d),
`ifdef CORY_UNPACK_SER_LEN_EN
    .i_a_len  (i_a_len),
`endif
    .o_a_r    (o_a_r),
    .o_z_v    (o_z_v),
    .o_z_d    (o_z_d),
    .o_z_last (o_z_last),
    .i_z_r    (i_z_r)
  );

  cory_unpack_ser #(.N(8), .M(1)) dut_m1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_a_v    (m1_a_v),
    .i_a_d    (m1_a_d),
`ifdef CORY_UNPACK_SER_LEN_EN
    .i_a_len  (m1_a_len),
`endif
    .o_a_r    (m1_a_r),
    .o_z_v    (m1_z_v),
    .o_z_d    (m1_z_d),
    .o_z_last (m1_z_last),
    .i_z_r    (m1_z_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
  task automatic drive(input logic av, input logic [31:0] ad, input logic zr);
    @(negedge clk);
    i_a_v = av;
    i_a_d = ad;
    i_z_r = zr;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    tests_run++; if (o_z_v !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_z_v got %b want 0", o_z_v); end
    tests_run++; if (o_z_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_z_last got %b want 0", o_z_last); end
    tests_run++; if (o_z_d !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_z_d got %h want 00", o_z_d); end
    tests_run++; if (o_a_r !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_a_r got %b want 1", o_a_r); end
    tests_run++; if (m1_a_r !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_m1_a_r got %b want 1", m1_a_r); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_single_word();
    logic [31:0] w;
    w = 32'h44332211;
    drive(1'b1, w, 1'b1);
    tests_run++; if (o_a_r !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_a_r got %b want 1", o_a_r); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, $urandom, 1'b1);
      tests_run++; if (o_z_v !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_v beat %0d got %b want 1", k, o_z_v); end
      tests_run++; if (o_z_d !== w[8*k +: 8]) begin tests_failed++; $display("[TB] FAIL single_d beat %0d got %h want %h", k, o_z_d, w[8*k +: 8]); end
      tests_run++; if (o_z_last !== (k == 3)) begin tests_failed++; $display("[TB] FAIL single_last beat %0d got %b want %b", k, o_z_last, (k == 3)); end
    end
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_v !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_idle_v got %b want 0", o_z_v); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] both;
    both = {32'h88776655, 32'h44332211};
    drive(1'b1, both[31:0], 1'b1);
    tests_run++; if (o_a_r !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first_a_r got %b want 1", o_a_r); end
    for (int i = 0; i < 8; i++) begin
      drive(i < 4, both[63:32], 1'b1);
      tests_run++; if (o_z_v !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_v beat %0d got %b want 1", i, o_z_v); end
      tests_run++; if (o_z_d !== both[8*i +: 8]) begin tests_failed++; $display("[TB] FAIL b2b_d beat %0d got %h want %h", i, o_z_d, both[8*i +: 8]); end
      tests_run++; if (o_z_last !== (i % 4 == 3)) begin tests_failed++; $display("[TB] FAIL b2b_last beat %0d got %b want %b", i, o_z_last, (i % 4 == 3)); end
      tests_run++; if (o_a_r !== (i % 4 == 3)) begin tests_failed++; $display("[TB] FAIL b2b_a_r beat %0d got %b want %b", i, o_a_r, (i % 4 == 3)); end
    end
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_v !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle_v got %b want 0", o_z_v); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'h44332211, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_d !== 8'h11) begin tests_failed++; $display("[TB] FAIL stall_first got %h want 11", o_z_d); end
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, $urandom, 1'b0);
      tests_run++; if (o_z_v !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_v cycle %0d got %b want 1", s, o_z_v); end
      tests_run++; if (o_z_d !== 8'h22) begin tests_failed++; $display("[TB] FAIL stall_d cycle %0d got %h want 22", s, o_z_d); end
      tests_run++; if (o_a_r !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_a_r cycle %0d got %b want 0", s, o_a_r); end
      tests_run++; if (o_z_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_last cycle %0d got %b want 0", s, o_z_last); end
    end
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_d !== 8'h22) begin tests_failed++; $display("[TB] FAIL stall_release got %h want 22", o_z_d); end
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_d !== 8'h33) begin tests_failed++; $display("[TB] FAIL stall_resume3 got %h want 33", o_z_d); end
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_d !== 8'h44 || o_z_last !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_resume4 got %h/%b want 44/1", o_z_d, o_z_last); end
    drive(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 32'h44332211, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_d !== 8'h22) begin tests_failed++; $display("[TB] FAIL mrst_pre got %h want 22", o_z_d); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++; if (o_z_v !== 1'b0) begin tests_failed++; $display("[TB] FAIL mrst_v got %b want 0", o_z_v); end
    tests_run++; if (o_z_d !== 8'h00) begin tests_failed++; $display("[TB] FAIL mrst_d got %h want 00", o_z_d); end
    tests_run++; if (o_a_r !== 1'b1) begin tests_failed++; $display("[TB] FAIL mrst_a_r got %b want 1", o_a_r); end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 32'hDDCCBBAA, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_d !== 8'hAA || o_z_v !== 1'b1) begin tests_failed++; $display("[TB] FAIL mrst_next got %h/%b want aa/1", o_z_d, o_z_v); end
    repeat (3) drive(1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_m1();
    logic [7:0] w [6];
    w[0] = 8'h5A;
    w[1] = 8'hA5;
    for (int j = 2; j < 6; j++) w[j] = 8'($urandom);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      m1_a_v = 1'b1;
      m1_a_d = w[j];
      #1;
      tests_run++; if (m1_a_r !== 1'b1) begin tests_failed++; $display("[TB] FAIL m1_a_r word %0d got %b want 1", j, m1_a_r); end
      if (j > 0) begin
        tests_run++; if (m1_z_v !== 1'b1 || m1_z_last !== 1'b1) begin tests_failed++; $display("[TB] FAIL m1_v_last word %0d got %b/%b want 1/1", j, m1_z_v, m1_z_last); end
        tests_run++; if (m1_z_d !== w[j-1]) begin tests_failed++; $display("[TB] FAIL m1_d word %0d got %h want %h", j, m1_z_d, w[j-1]); end
      end
    end
    @(negedge clk);
    m1_a_v = 1'b0;
    #1;
    tests_run++; if (m1_z_d !== w[5] || m1_z_last !== 1'b1) begin tests_failed++; $display("[TB] FAIL m1_tail got %h/%b want %h/1", m1_z_d, m1_z_last, w[5]); end
    @(negedge clk);
    #1;
    tests_run++; if (m1_z_v !== 1'b0) begin tests_failed++; $display("[TB] FAIL m1_idle_v got %b want 0", m1_z_v); end
  endtask

`ifdef CORY_UNPACK_SER_LEN_EN
  task automatic test_len();
    i_a_len = 2'd1;
    drive(1'b1, 32'h44332211, 1'b1);
    i_a_len = 2'd3;
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_d !== 8'h11 || o_z_last !== 1'b0) begin tests_failed++; $display("[TB] FAIL len_b0 got %h/%b want 11/0", o_z_d, o_z_last); end
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_d !== 8'h22 || o_z_last !== 1'b1) begin tests_failed++; $display("[TB] FAIL len_b1 got %h/%b want 22/1", o_z_d, o_z_last); end
    tests_run++; if (o_a_r !== 1'b1) begin tests_failed++; $display("[TB] FAIL len_a_r got %b want 1", o_a_r); end
    drive(1'b0, 32'h0, 1'b1);
    tests_run++; if (o_z_v !== 1'b0) begin tests_failed++; $display("[TB] FAIL len_idle_v got %b want 0", o_z_v); end
  endtask
`endif

  // Reference: a queue of the beats still owed for the current word; nothing about counters or flags.
  task automatic test_random();
    logic [7:0]  q [$];
    logic        pend;
    logic [31:0] pw;
    int          nb;
    logic        zr;
    logic        exp_v, exp_last, exp_r;
    pend = 1'b0;
    pw   = '0;
    nb   = 4;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend && ($urandom_range(0, 1) == 1)) begin
        pend = 1'b1;
        pw   = $urandom;
        nb   = 4;
`ifdef CORY_UNPACK_SER_LEN_EN
        nb      = $urandom_range(1, 4);
        i_a_len = 2'(nb - 1);
`endif
      end
      zr = ($urandom_range(0, 3) != 0);
      drive(pend, pend ? pw : $urandom, zr);
      exp_v    = (q.size() != 0);
      exp_last = (q.size() == 1);
      exp_r    = !exp_v || (zr && exp_last);
      tests_run++; if (o_z_v !== exp_v) begin tests_failed++; $display("[TB] FAIL rand_v cyc %0d got %b want %b", cyc, o_z_v, exp_v); end
      tests_run++; if (o_z_last !== exp_last) begin tests_failed++; $display("[TB] FAIL rand_last cyc %0d got %b want %b", cyc, o_z_last, exp_last); end
      tests_run++; if (o_a_r !== exp_r) begin tests_failed++; $display("[TB] FAIL rand_a_r cyc %0d got %b want %b", cyc, o_a_r, exp_r); end
      if (exp_v) begin
        tests_run++; if (o_z_d !== q[0]) begin tests_failed++; $display("[TB] FAIL rand_d cyc %0d got %h want %h", cyc, o_z_d, q[0]); end
      end
      if (exp_v && zr) void'(q.pop_front());
      if (pend && exp_r) begin
        for (int k = 0; k < nb; k++) q.push_back(pw[8*k +: 8]);
        pend = 1'b0;
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_a_v  = 1'b0;
    i_a_d  = '0;
    i_z_r  = 1'b0;
    m1_a_v = 1'b0;
    m1_a_d = '0;
    m1_z_r = 1'b1;
`ifdef CORY_UNPACK_SER_LEN_EN
    i_a_len  = 2'd3;
    m1_a_len = 1'b0;
`endif
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_mid_reset();
    test_m1();
`ifdef CORY_UNPACK_SER_LEN_EN
    test_len();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
